// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transceiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int DATA_BITS = 8;

  // Half a bit period in clock cycles: the mid-bit sampling offset.
  function automatic int half_bit(input int div16);
    return 8 * div16;
  endfunction

endpackage

// File: rtl/uart_rx_deser.sv
// Receive path: rxd synchroniser, falling-edge detect, mid-bit sampler
// with false-start rejection, and stop-bit framing check.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int DIV16 = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       fresh,
  output logic       frame_err
);

  localparam int BIT_CYC  = 16 * DIV16;
  localparam int HALF_BIT = half_bit(DIV16);
  localparam int CW       = $clog2(BIT_CYC);

  localparam logic [CW-1:0] BIT_END  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic          sync1;
  logic          rxs;
  logic          rxs_d;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      data      <= '0;
      fresh     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      fresh     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rxs_d && !rxs) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF_END) begin
            cnt   <= '0;
            idx   <= '0;
            // Line back high at mid start bit: a glitch, not a frame.
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            sh  <= {rxs, sh[7:1]};
            idx <= idx + 1'b1;
            if (idx == LAST_BIT) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            state <= IDLE;
            if (rxs) begin
              data  <= sh;
              fresh <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_core.sv
// 8N1 UART transceiver: inline transmitter plus the receive deserialiser.
// TX and RX share only the clock and reset.
module uart_core
  import uart_pkg::*;
#(
  parameter int    DIV16   = 27,
  localparam int   BIT_CYC = 16 * DIV16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_data_ack,
  output logic       txd,
  output logic [7:0] rx_data,
  output logic       rx_data_fresh,
  output logic       rx_frame_err,
  input  logic       rxd
);

  localparam int CW = $clog2(BIT_CYC);

  localparam logic [CW-1:0] BIT_END  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] ACK_AT   = CW'(BIT_CYC - 2);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      sh          <= '0;
      txd         <= 1'b1;
      tx_data_ack <= 1'b0;
    end else begin
      tx_data_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_data_valid) begin
            sh    <= tx_data;
            txd   <= 1'b0;
            cnt   <= '0;
            idx   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            txd   <= sh[0];
            state <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            if (idx == LAST_BIT) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              txd <= sh[1];
              sh  <= sh >> 1;
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Registered ack lands exactly on the last stop cycle.
          if (cnt == ACK_AT) tx_data_ack <= 1'b1;
          if (cnt == BIT_END) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_rx_deser #(
    .DIV16(DIV16)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .data     (rx_data),
    .fresh    (rx_data_fresh),
    .frame_err(rx_frame_err)
  );

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: queued expectations, separate TX/RX
// monitors, randomized payloads against a frame-level reference model.
module tb_uart_core;

  localparam int DIV16 = 4;
  localparam int BITC  = 64;
  localparam int FRAME = 10 * BITC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_data_valid = 1'b0;
  logic       tx_data_ack;
  logic       txd;
  logic [7:0] rx_data;
  logic       rx_data_fresh;
  logic       rx_frame_err;
  logic       rxd;
  logic       rxd_drv = 1'b1;
  logic       loopb = 1'b0;

  assign rxd = loopb ? txd : rxd_drv;

  uart_core #(
    .DIV16(DIV16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_data      (tx_data),
    .tx_data_valid(tx_data_valid),
    .tx_data_ack  (tx_data_ack),
    .txd          (txd),
    .rx_data      (rx_data),
    .rx_data_fresh(rx_data_fresh),
    .rx_frame_err (rx_frame_err),
    .rxd          (rxd)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } rx_ev_t;

  int         n_checks = 0;
  int         n_fail = 0;
  longint     cyc = 0;
  int         ack_cnt = 0;
  int         rx_evt = 0;
  logic [7:0] tx_exp[$];
  rx_ev_t     rx_exp[$];
  longint     tx_starts[$];
  logic [7:0] last_rx = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tx_data_ack === 1'b1) ack_cnt <= ack_cnt + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return d[k-1];
  endfunction

  // TX monitor: every cycle of a frame against the ideal 8N1 waveform.
  initial begin : tx_mon
    logic [7:0] e;
    int         bad;
    int         ackbad;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || txd !== 1'b0) continue;
      tx_starts.push_back(cyc);
      if (tx_exp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_unexpected: frame started, none expected");
        e = 8'h00;
      end else begin
        e = tx_exp.pop_front();
      end
      bad = 0;
      ackbad = 0;
      aborted = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
        if (k > 0) @(negedge clk);
        if (rst !== 1'b0) begin
          aborted = 1'b1;
          break;
        end
        if (txd !== frame_bit(e, k / BITC)) bad++;
        if (tx_data_ack !== (k == FRAME - 1)) ackbad++;
      end
      if (aborted) begin
        while (rst !== 1'b0) @(negedge clk);
      end else begin
        check($sformatf("tx_wave_%02h", e), bad, 0);
        check($sformatf("tx_ack_timing_%02h", e), ackbad, 0);
      end
    end
  end

  // RX monitor: every fresh/err pulse consumes one expectation.
  initial begin : rx_mon
    rx_ev_t e;
    forever begin
      @(negedge clk);
      if (rx_data_fresh === 1'b1 || rx_frame_err === 1'b1) begin
        rx_evt++;
        if (rx_exp.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_unexpected: fresh=%b err=%b data=%02h",
                   rx_data_fresh, rx_frame_err, rx_data);
        end else begin
          e = rx_exp.pop_front();
          check("rx_err_pulse", rx_frame_err, e.err);
          check("rx_fresh_pulse", rx_data_fresh, !e.err);
          check("rx_data", rx_data, e.data);
        end
      end
    end
  end

  task automatic tx_send(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_data_valid = 1'b1;
    @(negedge clk);
    tx_data_valid = 1'b0;
  endtask

  task automatic wait_ack(input int target, input string name);
    int k = 0;
    while (ack_cnt < target && k < 2 * FRAME) begin
      @(negedge clk);
      k++;
    end
    check(name, ack_cnt, target);
  endtask

  task automatic wait_ack_pulse(output bit ok);
    int k = 0;
    ok = 1'b0;
    while (k < 2 * FRAME) begin
      @(negedge clk);
      k++;
      if (tx_data_ack === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input int bl, input bit stop_ok);
    for (int k = 0; k < 10; k++) begin
      rxd_drv = (k == 9) ? stop_ok : frame_bit(d, k);
      repeat (bl) @(negedge clk);
    end
    rxd_drv = 1'b1;
    repeat (bl) @(negedge clk);
  endtask

  task automatic expect_rx(input logic [7:0] d, input bit err);
    rx_ev_t e;
    e.err = err;
    e.data = err ? last_rx : d;
    if (!err) last_rx = d;
    rx_exp.push_back(e);
  endtask

  initial begin : stim
    logic [7:0] b;
    bit         ok;
    int         k;
    int         ev0;
    longint     gap;

    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_ack", tx_data_ack, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_fresh", rx_data_fresh, 0);
    check("rst_err", rx_frame_err, 0);
    rst = 1'b0;

    // Reset in the middle of a frame.
    b = 8'($urandom_range(1, 255));
    tx_exp.push_back(b);
    tx_send(b);
    repeat (200) @(negedge clk);
    check("mid_txd_low", txd, frame_bit(b, 202 / BITC));
    #2 rst = 1'b1;
    #1 check("async_rst_txd", txd, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ack", tx_data_ack, 0);
    check("post_rst_rx_data", rx_data, 0);
    check("post_rst_ack_cnt", ack_cnt, 0);

    tx_exp.push_back(8'hA5);
    tx_send(8'hA5);
    wait_ack(1, "ack_a5");
    repeat (100) @(negedge clk);
    check("ack_a5_once", ack_cnt, 1);

    // Busy drop: a request during a frame vanishes.
    tx_exp.push_back(8'h3C);
    tx_send(8'h3C);
    repeat (300) @(negedge clk);
    tx_send(8'hFF);
    wait_ack(2, "ack_3c");
    repeat (100) @(negedge clk);
    check("busy_drop_acks", ack_cnt, 2);
    check("busy_drop_queue", tx_exp.size(), 0);

    // Held request: back-to-back frames, one idle cycle between.
    tx_exp.push_back(8'h11);
    tx_exp.push_back(8'h22);
    @(negedge clk);
    tx_data = 8'h11;
    tx_data_valid = 1'b1;
    wait_ack_pulse(ok);
    check("held_ack1", ok, 1);
    tx_data = 8'h22;
    wait_ack_pulse(ok);
    check("held_ack2", ok, 1);
    tx_data_valid = 1'b0;
    repeat (100) @(negedge clk);
    gap = (tx_starts.size() >= 2) ?
          tx_starts[tx_starts.size()-1] - tx_starts[tx_starts.size()-2] : 0;
    check("back_to_back_gap", 32'(gap), FRAME + 1);
    check("held_acks", ack_cnt, 4);

    // Loopback good frame.
    loopb = 1'b1;
    tx_exp.push_back(8'h5A);
    expect_rx(8'h5A, 1'b0);
    tx_send(8'h5A);
    wait_ack(5, "ack_5a");
    repeat (100) @(negedge clk);
    check("loop_rx_evt", rx_evt, 1);
    loopb = 1'b0;

    // Short glitch rejected as a false start.
    ev0 = rx_evt;
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (20) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (FRAME + 100) @(negedge clk);
    check("glitch_no_pulse", rx_evt, ev0);

    // Framing error keeps last good byte.
    expect_rx(8'h81, 1'b1);
    send_rx(8'h81, BITC, 1'b0);
    repeat (50) @(negedge clk);
    check("frame_err_seen", rx_evt, ev0 + 1);
    check("frame_err_hold", rx_data, 8'h5A);

    // Baud skew +3% / -3% with simultaneous TX.
    foreach (tx_starts[i]) k = i;
    for (int s = 0; s < 2; s++) begin
      b = 8'($urandom);
      expect_rx(8'hC3, 1'b0);
      tx_exp.push_back(8'h0F);
      fork
        send_rx(8'hC3, (s == 0) ? 66 : 62, 1'b1);
        tx_send(8'h0F);
      join
      wait_ack(6 + s, $sformatf("ack_skew%0d", s));
      // A random good frame at nominal baud between skew runs.
      expect_rx(b, 1'b0);
      send_rx(b, BITC, 1'b1);
    end

    k = 0;
    while ((tx_exp.size() != 0 || rx_exp.size() != 0) && k < 4 * FRAME) begin
      @(negedge clk);
      k++;
    end
    repeat (FRAME) @(negedge clk);
    check("tx_queue_drained", tx_exp.size(), 0);
    check("rx_queue_drained", rx_exp.size(), 0);
    check("total_acks", ack_cnt, 7);
    check("total_rx_events", rx_evt, 6);
    check("final_rx_data", rx_data, last_rx);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_core.md
# uart_core

8N1 UART transceiver on the UART clock domain, consumed by the peripherals block: it serialises one byte per `tx_data_valid` request onto `txd` and deserialises `rxd` into `rx_data` with a one-cycle `rx_data_fresh` strobe. Bit timing comes from an integer divider parameter. A mid-bit sampler with a synchronised input and false-start rejection recovers receive data.

## Interface
- `DIV16`, default 27: UART clock cycles per 1/16 bit, for 50 MHz at 115200 baud; must be ≥ 2.
- `BIT_CYC`, default `16*DIV16`: cycles per bit; derived, not overridden.
- `clk`, in, 1: UART clock, all logic on the rising edge.
- `rst`, in, 1: reset; one clock, reset asynchronous and active-high.
- `tx_data`, in, 8: byte to send, sampled when a request is accepted.
- `tx_data_valid`, in, 1: transmit request.
- `tx_data_ack`, out, 1: one-cycle pulse when the stop bit of the accepted byte completes.
- `txd`, out, 1: serial output, idle high.
- `rx_data`, out, 8: last correctly framed received byte.
- `rx_data_fresh`, out, 1: one-cycle pulse when `rx_data` updates.
- `rx_frame_err`, out, 1: one-cycle pulse when the stop bit samples low.
- `rxd`, in, 1: serial input, asynchronous.

## Operation
- **Reset values:** `txd`=1, `tx_data_ack`=0, `rx_data`=0x00, `rx_data_fresh`=0, `rx_frame_err`=0. Both FSMs are IDLE, counters are 0, and the `rxd` synchroniser flops are 1.
- **TX FSM (IDLE → START → DATA → STOP → IDLE):**
  - In IDLE with `tx_data_valid`=1: latch `tx_data` into the shift register and enter START.
  - `tx_data_valid` in any other state is ignored. No queueing; the request is dropped.
  - START drives 0 for `BIT_CYC` cycles.
  - DATA drives the LSB first, 8 bits of `BIT_CYC` cycles each, with a 3-bit bit index.
  - STOP drives 1 for `BIT_CYC` cycles. `tx_data_ack` pulses on the last STOP cycle, and the FSM returns to IDLE on the next edge.
  - `txd` is registered (no glitches).
  - A request held high continuously is re-accepted in the first IDLE cycle, giving back-to-back frames with no extra idle bit.
- **RX synchroniser and edge detect:**
  - `rxd` passes through two flops to give `rxs`. A third flop gives `rxs_d` for edge detection.
- **RX FSM (IDLE → START → DATA → STOP → IDLE):**
  - IDLE: a falling edge (`rxs_d`=1, `rxs`=0) clears the counter and enters START.
  - START: at count `8*DIV16-1` (mid start bit), `rxs`=0 goes to DATA with the counter cleared. `rxs`=1 is a false start and returns to IDLE with no output pulse.
  - DATA: sample `rxs` every `BIT_CYC` cycles (mid-bit) into a right-shifting register, LSB first. Go to STOP after the 8th sample.
  - STOP: after `BIT_CYC` cycles, sample `rxs`.
    - If 1: load `rx_data` and pulse `rx_data_fresh`.
    - If 0: pulse `rx_frame_err` and leave `rx_data` unchanged.
    - Either way, return to IDLE immediately. This is mid stop bit, so re-arming for the next start edge leaves half a bit of margin.
- **Channel independence:** TX and RX are fully independent; simultaneous activity has no interaction.
- **Counter width:** `$clog2(BIT_CYC)` bits. Counters are compared against constants and never wrap.
- **Reset mid-frame:** `txd` returns to 1 asynchronously and any partial RX byte is discarded.

## Timing
- **TX latency:** `tx_data_valid` high with IDLE at edge N → `txd`=0 from edge N+1.
- **TX frame length:** exactly `10*BIT_CYC` cycles from `txd` falling to `tx_data_ack` high, inclusive of the ack cycle.
- **RX latency:** `rx_data_fresh` is asserted `2 + 8*DIV16 + 9*BIT_CYC` cycles (±1) after the `rxd` falling edge. `rx_data` is valid in the same cycle and holds until the next good frame.
- **RX tolerance:** about ±4% baud mismatch, from the mid-bit sampling window.

## Structure
- Shared package `uart_pkg`:
  - state enum `{IDLE, START, DATA, STOP}`, used by both FSMs;
  - constants `DATA_BITS=8`, `HALF_BIT=8*DIV16`.
- One sub-module, `uart_rx_deser`: synchroniser, RX FSM, counter and shift register.
- TX stays inline in `uart_core`.

## Test plan
All scenarios use `DIV16`=4, so `BIT_CYC`=64.
- **Reset:** assert `rst` mid-TX-frame → `txd`=1 immediately. After release, `tx_data_ack`=0 and `rx_data`=0x00, and a new request transmits normally.
- **TX 0xA5:** pulse `tx_data_valid` → `txd` bit sequence 0,1,0,1,0,0,1,0,1,1 with 64 cycles per bit. `tx_data_ack` pulses exactly once, 640 cycles after the start edge.
- **TX busy drop:** send 0x3C, then pulse a request with 0xFF mid-frame → only 0x3C appears, one ack. A held request then yields back-to-back frames with no gap.
- **RX good frame:** loop `txd`→`rxd` and send 0x5A → `rx_data`=0x5A with one `rx_data_fresh` pulse, and `rx_frame_err` stays 0.
- **RX errors:**
  - A 20-cycle low glitch on `rxd` → no pulse of either kind.
  - A frame 0x81 with the stop bit forced low → `rx_frame_err` pulses and `rx_data` keeps its previous value.
- **RX baud skew:** drive 0xC3 at +3% and −3% bit period, plus simultaneous TX of 0x0F → both bytes are correct on their respective outputs.
